// File: rtl/data_mem_ctrl_pkg.sv
// Shared CPU package: memory widths and the data-memory controller FSM encoding,
// so the control unit, datapath and memory agree on sizes and state values.
package data_mem_ctrl_pkg;

  localparam int CPU_ADDR_W = 11;
  localparam int CPU_DATA_W = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the control unit (master) and the data memory (slave).
interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) ();

  logic [ADDR_W-1:0] addr;
  logic              wr_ram;
  logic              rd_ram;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ready;

  modport master (
    output addr, wr_ram, rd_ram, wr_data,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  addr, wr_ram, rd_ram, wr_data,
    output rd_data, rd_valid, ready
  );

endinterface

// File: rtl/data_mem_ctrl_ram_sp.sv
// Single-port synchronous RAM, write-first, with a registered read port that
// holds its value between reads and clears on reset (array contents are not reset).
module ram_sp #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Array write port; kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Registered read; a same-cycle write to the port forwards the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_we ? i_wdata : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the accumulator CPU. After reset it optionally sweeps
// the array to zero while holding ready low, then serves one access per cycle.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = CPU_ADDR_W,
  parameter int DATA_W         = CPU_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            reset,
  data_mem_ctrl_if.slave bus
);

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_ready;
  logic              r_rd_valid;

  logic              w_sweep_last;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_sweep_last = (r_clr_cnt == {ADDR_W{1'b1}});

  // Control FSM: sweep counter, ready and rd_valid are all registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RESET_STATE;
      r_clr_cnt  <= '0;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_rd_valid <= 1'b0;
          r_clr_cnt  <= r_clr_cnt + ADDR_W'(1);
          if (w_sweep_last) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end else begin
            r_ready <= 1'b0;
          end
        end
        RUN: begin
          r_ready    <= 1'b1;
          r_rd_valid <= bus.rd_ram;
        end
        default: begin
          r_state <= RESET_STATE;
        end
      endcase
    end
  end

  // RAM port mux: the sweep owns the port in CLEAR, core requests are ignored there.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (r_state == CLEAR) begin
      w_ram_we   = 1'b1;
      w_ram_addr = r_clr_cnt;
    end else begin
      w_ram_we    = bus.wr_ram;
      w_ram_re    = bus.rd_ram;
      w_ram_addr  = bus.addr;
      w_ram_wdata = bus.wr_data;
    end
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.rd_data  = w_ram_rdata;
  assign bus.rd_valid = r_rd_valid;
  assign bus.ready    = r_ready;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus randomized traffic checked
// against a plain array model of the memory and its read register.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int AW    = CPU_ADDR_W;
  localparam int DW    = CPU_DATA_W;
  localparam int DEPTH = 2**AW;

  logic clk;
  logic reset;

  data_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  data_mem_ctrl #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_rd;
  logic          exp_valid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_ram  = wr;
    bus.rd_ram  = rd;
    bus.addr    = a;
    bus.wr_data = d;
  endtask

  // One RUN-mode transaction: apply, clock, then advance the model (write-first).
  task automatic access(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(wr, rd, a, d);
    step();
    if (wr) model_mem[a] = d;
    if (rd) exp_rd = model_mem[a];
    exp_valid = rd;
    $display("txn wr=%0d rd=%0d addr=%h wdata=%h -> rd_data=%h rd_valid=%0d ready=%0d",
             wr, rd, a, d, bus.rd_data, bus.rd_valid, bus.ready);
  endtask

  // Release reset with junk requests held on the bus, count edges until ready.
  task automatic run_sweep(output int edges, output bit saw_valid);
    edges     = 0;
    saw_valid = 1'b0;
    drive(1'b1, 1'b1, '0, 16'hFFFF);
    reset = 1'b1;
    do begin
      step();
      edges++;
      if (bus.rd_valid !== 1'b0) saw_valid = 1'b1;
    end while (bus.ready !== 1'b1 && edges < 3000);
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_rd    = '0;
    exp_valid = 1'b0;
    $display("txn sweep done after %0d edges", edges);
  endtask

  task automatic test_reset();
    int  edges;
    bit  saw_valid;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) step();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", bus.rd_data); end
    run_sweep(edges, saw_valid);
    total++; if (edges !== DEPTH) begin bad++; $display("FAIL sweep_latency got=%0d exp=%0d", edges, DEPTH); end
    total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL sweep_rd_valid got=1 exp=0"); end
    access(1'b0, 1'b1, 11'h7FF, '0);
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL read_7ff_valid got=%b exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL read_7ff_data got=%h exp=0000", bus.rd_data); end
    access(1'b0, 1'b1, 11'h000, '0);
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL clear_ignores_write got=%h exp=0000", bus.rd_data); end
    access(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_write_read();
    access(1'b1, 1'b0, 11'h005, 16'hBEEF);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL write_no_valid got=%b exp=0", bus.rd_valid); end
    access(1'b0, 1'b1, 11'h005, '0);
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL wr_rd_valid got=%b exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_data got=%h exp=BEEF", bus.rd_data); end
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b0, '0, '0);
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, bus.rd_valid); end
      total++; if (bus.rd_data !== 16'hBEEF) begin bad++; $display("FAIL idle_hold[%0d] got=%h exp=BEEF", i, bus.rd_data); end
    end
  endtask

  task automatic test_simultaneous();
    access(1'b1, 1'b1, 11'h010, 16'h1234);
    total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%b exp=1", bus.rd_valid); end
    total++; if (bus.rd_data !== 16'h1234) begin bad++; $display("FAIL simul_data got=%h exp=1234", bus.rd_data); end
    access(1'b0, 1'b0, '0, '0);
    access(1'b0, 1'b1, 11'h010, '0);
    total++; if (bus.rd_data !== 16'h1234) begin bad++; $display("FAIL simul_reread got=%h exp=1234", bus.rd_data); end
    access(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want [3];
    want[0] = 16'h0011; want[1] = 16'h0022; want[2] = 16'h0033;
    for (int i = 0; i < 3; i++) access(1'b1, 1'b0, AW'(i + 1), want[i]);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, AW'(i + 1), '0);
      total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.rd_valid); end
      total++; if (bus.rd_data !== want[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.rd_data, want[i]); end
    end
    access(1'b0, 1'b0, '0, '0);
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", bus.rd_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      int            op;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      d  = DW'($urandom);
      access(op[0], op[1], a, d);
      total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rand_ready[%0d] got=%b exp=1", n, bus.ready); end
      total++; if (bus.rd_valid !== exp_valid) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, bus.rd_valid, exp_valid); end
      total++; if (bus.rd_data !== exp_rd) begin bad++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", n, a, bus.rd_data, exp_rd); end
    end
    access(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    int edges;
    bit saw_valid;
    access(1'b1, 1'b0, 11'h3FF, 16'h00AA);
    access(1'b0, 1'b1, 11'h3FF, '0);
    total++; if (bus.rd_data !== 16'h00AA) begin bad++; $display("FAIL pre_reset_data got=%h exp=00AA", bus.rd_data); end
    // Asynchronous drop mid-access, observed before any clock edge.
    reset = 1'b0;
    #2;
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL async_rd_data got=%h exp=0000", bus.rd_data); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL async_rd_valid got=%b exp=0", bus.rd_valid); end
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL async_ready got=%b exp=0", bus.ready); end
    drive(1'b0, 1'b0, '0, '0);
    step();
    reset = 1'b1;
    repeat (100) step();
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL midsweep_ready got=%b exp=0", bus.ready); end
    reset = 1'b0;
    #2;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL midsweep_reset_ready got=%b exp=0", bus.ready); end
    step();
    run_sweep(edges, saw_valid);
    total++; if (edges !== DEPTH) begin bad++; $display("FAIL restart_latency got=%0d exp=%0d", edges, DEPTH); end
    access(1'b0, 1'b1, 11'h3FF, '0);
    total++; if (bus.rd_data !== 16'h0000) begin bad++; $display("FAIL reread_3ff got=%h exp=0000", bus.rd_data); end
    access(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    exp_rd    = '0;
    exp_valid = 1'b0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
